flappy_game_ctrl: RTL
=====================

Name: flappy_game_ctrl

Overview:
- Game-flow controller sitting between the debounced flap button, the VGA frame timer, the pipe/collision datapath and the score displays.
- Sequences each game through IDLE -> PLAY -> DYING -> OVER.
- Owns bird vertical physics (position, velocity), pipe-scroll enable, current BCD score and best BCD score; drives the SEGLED score path.

Parameters:
- Y_START, 240: bird row after reset and on each new game.
- Y_TOP, 0: upper clamp for bird_y.
- Y_BOTTOM, 440: ground row; reaching it in PLAY kills the bird.
- GRAVITY, 1: velocity increment per frame.
- FLAP_IMPULSE, 8: velocity set to -FLAP_IMPULSE on a flap.
- VMAX, 10: maximum downward velocity.
- DEATH_FRAMES, 60: frames spent in DYING.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per VGA frame
- flap  in  1  debounced button level; rising edge detected internally
- collide  in  1  bird/pipe overlap; sampled only on frame_tick
- pipe_passed  in  1  one-cycle pulse when the bird clears a pipe
- pause_sw  in  1  freezes physics and scroll while high
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER
- bird_y  out  10  bird row
- bird_vel  out  6  signed velocity, two's complement
- scroll_en  out  1  pipe datapath advances while high
- score_bcd  out  16  4-digit BCD current score
- best_bcd  out  16  4-digit BCD best score
- new_best  out  1  high in OVER when the last game set the best

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, bird_y=Y_START, bird_vel=0, scroll_en=0, score_bcd=0, best_bcd=0, new_best=0.
  - Flap edge register and death counter cleared.
- Flap edge:
  - flap_q is registered; edge = flap & ~flap_q.
  - In PLAY, an edge sets flap_pending, which is consumed by the next unpaused frame_tick.
  - An edge in the same cycle as frame_tick is consumed by that tick.
- IDLE:
  - bird held at Y_START, vel 0, scroll_en=0.
  - Flap edge -> PLAY next cycle, with flap_pending=1.
- PLAY, on frame_tick with pause_sw=0:
  - vel' = flap_pending ? -FLAP_IMPULSE : min(vel+GRAVITY, VMAX).
  - y' = clamp(y+vel', Y_TOP, Y_BOTTOM); signed arithmetic at 11 bits, then clamped.
  - Clear flap_pending.
  - If collide=1 or y'>=Y_BOTTOM -> DYING, load death counter = DEATH_FRAMES.
- PLAY, other rules:
  - scroll_en = (state==PLAY) & ~pause_sw, combinational from registered state.
  - pipe_passed in any PLAY cycle (paused or not) increments score_bcd with per-digit carry; saturates at 9999.
  - pipe_passed and collide in the same frame: the score increment still counts.
- DYING:
  - scroll_en=0; flap ignored.
  - Each frame_tick applies gravity only (no pause effect), clamped at Y_BOTTOM, and decrements the counter.
  - At counter 0 -> OVER. On that transition: if score_bcd > best_bcd (unsigned BCD compare) then best_bcd <= score_bcd and new_best <= 1.
- OVER:
  - Outputs frozen.
  - Flap edge -> IDLE: bird_y=Y_START, vel=0, score_bcd=0, new_best=0; best_bcd retained.
- General:
  - pipe_passed and collide outside PLAY are ignored.
  - Reset mid-operation returns to reset values immediately.

Optional Feature:
- FLAPPY_GOD_MODE_EN defined:
  - collide ignored in PLAY.
  - Reaching Y_BOTTOM clamps y and forces vel=0 instead of entering DYING.
  - Game never ends; used for board demos and long scroll tests.
- Undefined: behaviour exactly as above.

Decomposition:
- flappy_pkg:
  - state encoding constants (IDLE/PLAY/DYING/OVER)
  - BCD digit width
  - default geometry constants (Y_START, Y_BOTTOM, FLAP_IMPULSE, GRAVITY, VMAX)
- One sub-module, bcd_counter4:
  - 4-digit BCD incrementer with saturating 9999 and synchronous clear.
  - Instantiated for score_bcd; best_bcd is a plain register plus comparator in the parent.

Test Plan:
- Reset low then high -> state=0, bird_y=240, bird_vel=0, score_bcd=0x0000, scroll_en=0.
- Flap pulse in IDLE, then 3 frame_ticks -> state=1; (vel,y) = (-8,232), (-7,225), (-6,219); scroll_en=1.
- No further flaps from (240,0) -> vel saturates at 10 on tick 10 (y=295); tick 25 y clamps 440 -> state=2; 60 ticks later state=3.
- Score and best tracking:
  - 12 pipe_passed pulses, then collide on a tick -> score 0x0012, DYING; OVER gives best_bcd=0x0012, new_best=1.
  - Next game scores 5 -> best stays 0x0012, new_best=0.
- Preload via 9999 pulses, then 1 more -> score_bcd stays 0x9999.
- Pause and reset mid-game:
  - pause_sw=1 in PLAY over 10 ticks -> bird_y, bird_vel unchanged, scroll_en=0; pipe_passed still counts.
  - rst low mid-DYING -> all reset values next cycle.

Source files
------------

// File: rtl/flappy_pkg.sv
// -----------------------------------------------------------------------------
// flappy_pkg
// Shared definitions for the flappy game controller.
//   - state_t          : game-flow state encoding (IDLE/PLAY/DYING/OVER)
//   - BCD_DIGIT_W/DIGITS : score digit geometry
//   - Y_W / VEL_W      : widths of bird row and signed velocity
//   - DEF_*            : default geometry and physics constants
// -----------------------------------------------------------------------------
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 4;

    localparam int Y_W   = 10;
    localparam int VEL_W = 6;

    localparam int DEF_Y_START      = 240;
    localparam int DEF_Y_TOP        = 0;
    localparam int DEF_Y_BOTTOM     = 440;
    localparam int DEF_GRAVITY      = 1;
    localparam int DEF_FLAP_IMPULSE = 8;
    localparam int DEF_VMAX         = 10;
    localparam int DEF_DEATH_FRAMES = 60;

endpackage

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter, saturating at 9999, with synchronous clear.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset (count -> 0)
//   clr    in   synchronous clear, wins over inc
//   inc    in   add one this cycle (ignored once the count reads 9999)
//   count  out  16-bit packed BCD value, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bcd_counter4
    import flappy_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic                                inc,
    output logic [BCD_DIGITS*BCD_DIGIT_W-1:0]   count
);

    localparam int CW = BCD_DIGITS * BCD_DIGIT_W;
    localparam logic [CW-1:0] ALL_NINES = {BCD_DIGITS{4'h9}};

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         count_inc;
    logic [BCD_DIGITS-1:0] carry;

    // Blocking the carry into digit 0 at 9999 is what makes the counter saturate.
    assign carry[0] = inc & (count_q != ALL_NINES);

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [BCD_DIGIT_W-1:0] digit;
            assign digit = count_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W];
            assign count_inc[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
                carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
            if (gi < BCD_DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit == 4'd9);
            end
        end
    endgenerate

    always_comb begin
        count_d = clr ? '0 : count_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
// Game-flow controller: IDLE -> PLAY -> DYING -> OVER -> IDLE.
// Owns bird physics (row, signed velocity), pipe scroll enable, current and
// best BCD scores.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   flap         in   debounced button level (rising edge used)
//   collide      in   bird/pipe overlap, looked at on unpaused PLAY frames
//   pipe_passed  in   one-cycle pulse when a pipe is cleared
//   pause_sw     in   freezes physics and scroll in PLAY
//   state        out  0=IDLE 1=PLAY 2=DYING 3=OVER
//   bird_y       out  bird row
//   bird_vel     out  signed velocity (positive = downward)
//   scroll_en    out  pipe datapath advance enable
//   score_bcd    out  current score, 4-digit BCD
//   best_bcd     out  best score, 4-digit BCD
//   new_best     out  in OVER: the game just finished set the best
// Build option:
//   FLAPPY_GOD_MODE_EN - collisions ignored, ground clamps and zeroes
//                        velocity instead of killing the bird.
// -----------------------------------------------------------------------------
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int Y_START      = DEF_Y_START,
    parameter int Y_TOP        = DEF_Y_TOP,
    parameter int Y_BOTTOM     = DEF_Y_BOTTOM,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int FLAP_IMPULSE = DEF_FLAP_IMPULSE,
    parameter int VMAX         = DEF_VMAX,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    flap,
    input  logic                    collide,
    input  logic                    pipe_passed,
    input  logic                    pause_sw,
    output logic [1:0]              state,
    output logic [Y_W-1:0]          bird_y,
    output logic signed [VEL_W-1:0] bird_vel,
    output logic                    scroll_en,
    output logic [15:0]             score_bcd,
    output logic [15:0]             best_bcd,
    output logic                    new_best
);

    localparam int CNT_W = $clog2(DEATH_FRAMES + 1);
    localparam logic signed [VEL_W-1:0] VEL_FLAP = VEL_W'(-FLAP_IMPULSE);

    state_t                  state_q, state_d;
    logic [Y_W-1:0]          bird_y_q, bird_y_d;
    logic signed [VEL_W-1:0] bird_vel_q, bird_vel_d;
    logic                    flap_q, flap_d;
    logic                    flap_pending_q, flap_pending_d;
    logic [CNT_W-1:0]        death_cnt_q, death_cnt_d;
    logic [15:0]             best_q, best_d;
    logic                    new_best_q, new_best_d;

    logic                    score_clr;
    logic                    score_inc;
    logic [15:0]             score_w;

    logic                    flap_edge;
    logic                    play_step;
    logic                    play_die;
    logic                    dying_done;

    logic signed [VEL_W:0]   vel_inc;
    logic signed [VEL_W-1:0] vel_grav;
    logic signed [VEL_W-1:0] vel_play;
    logic signed [VEL_W-1:0] vel_step;
    logic signed [Y_W:0]     y_sum;
    logic [Y_W-1:0]          y_clamped;
    logic                    hit_bottom;

    assign flap_edge = flap & ~flap_q;
    assign play_step = (state_q == ST_PLAY) & frame_tick & ~pause_sw;
`ifdef FLAPPY_GOD_MODE_EN
    assign play_die  = 1'b0;
`else
    assign play_die  = play_step & (collide | hit_bottom);
`endif
    // Last DYING frame: the tick that takes the counter from 1 to 0.
    assign dying_done = (state_q == ST_DYING) & frame_tick & (death_cnt_q <= CNT_W'(1));

    // ---------------- physics candidate for this frame ----------------
    always_comb begin
        vel_inc  = {bird_vel_q[VEL_W-1], bird_vel_q} + (VEL_W+1)'(GRAVITY);
        vel_grav = (vel_inc > $signed((VEL_W+1)'(VMAX))) ? VEL_W'(VMAX) : vel_inc[VEL_W-1:0];
        // An edge arriving on the tick itself counts as a flap for that tick.
        vel_play = (flap_pending_q | flap_edge) ? VEL_FLAP : vel_grav;
        vel_step = (state_q == ST_DYING) ? vel_grav : vel_play;
        // 11-bit signed sum so upward motion past row 0 is seen as negative.
        y_sum    = $signed({1'b0, bird_y_q})
                 + $signed({{(Y_W+1-VEL_W){vel_step[VEL_W-1]}}, vel_step});
        hit_bottom = (y_sum >= $signed((Y_W+1)'(Y_BOTTOM)));
        if (y_sum < $signed((Y_W+1)'(Y_TOP))) begin
            y_clamped = Y_W'(Y_TOP);
        end else if (hit_bottom) begin
            y_clamped = Y_W'(Y_BOTTOM);
        end else begin
            y_clamped = y_sum[Y_W-1:0];
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            bird_y_q       <= Y_W'(Y_START);
            bird_vel_q     <= '0;
            flap_q         <= 1'b0;
            flap_pending_q <= 1'b0;
            death_cnt_q    <= '0;
            best_q         <= '0;
            new_best_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bird_y_q       <= bird_y_d;
            bird_vel_q     <= bird_vel_d;
            flap_q         <= flap_d;
            flap_pending_q <= flap_pending_d;
            death_cnt_q    <= death_cnt_d;
            best_q         <= best_d;
            new_best_q     <= new_best_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (flap_edge)  state_d = ST_PLAY;
            ST_PLAY:  if (play_die)   state_d = ST_DYING;
            ST_DYING: if (dying_done) state_d = ST_OVER;
            ST_OVER:  if (flap_edge)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        flap_d         = flap;
        bird_y_d       = bird_y_q;
        bird_vel_d     = bird_vel_q;
        flap_pending_d = flap_pending_q;
        death_cnt_d    = death_cnt_q;
        best_d         = best_q;
        new_best_d     = new_best_q;
        score_clr      = 1'b0;
        score_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bird_y_d       = Y_W'(Y_START);
                bird_vel_d     = '0;
                // The starting press becomes the first flap of the game.
                flap_pending_d = flap_edge;
            end
            ST_PLAY: begin
                // Scoring runs even while paused or on a colliding frame.
                score_inc = pipe_passed;
                if (play_step) begin
                    bird_vel_d     = vel_play;
                    bird_y_d       = y_clamped;
                    flap_pending_d = 1'b0;
`ifdef FLAPPY_GOD_MODE_EN
                    if (hit_bottom) begin
                        bird_vel_d = '0;
                    end
`endif
                    if (play_die) begin
                        death_cnt_d = CNT_W'(DEATH_FRAMES);
                    end
                end else if (flap_edge) begin
                    flap_pending_d = 1'b1;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    bird_vel_d  = vel_grav;
                    bird_y_d    = y_clamped;
                    death_cnt_d = death_cnt_q - CNT_W'(1);
                    // Valid BCD orders the same as plain binary.
                    if (dying_done && (score_w > best_q)) begin
                        best_d     = score_w;
                        new_best_d = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (flap_edge) begin
                    bird_y_d       = Y_W'(Y_START);
                    bird_vel_d     = '0;
                    flap_pending_d = 1'b0;
                    new_best_d     = 1'b0;
                    score_clr      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        state     = state_q;
        bird_y    = bird_y_q;
        bird_vel  = bird_vel_q;
        scroll_en = (state_q == ST_PLAY) & ~pause_sw;
        score_bcd = score_w;
        best_bcd  = best_q;
        new_best  = new_best_q;
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score_w)
    );

endmodule
